fifo_rd_stream: RTL and testbench

- Read-side consumer of async_fifo, in the rdclk domain.
- Drives the FIFO read port (rden/rddata/empty) and absorbs the RAM's 1-cycle read latency.
- Presents the data as a valid/ready stream with packet framing: m_last on every PKT_LEN-th beat.
- Keeps a completed-packet counter for downstream DMA/packet logic.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_rd_stream_if.sv | 39 +++
 rtl/stream_buf3.sv | 58 +++++
 rtl/fifo_rd_stream.sv | 85 ++++++++
 tb/tb_fifo_rd_stream.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, types and pointer helper for the async_fifo read-side stream logic.
package fifo_pkg;

  // Depth of the output register buffer. It covers one word held for the
  // consumer, one word arriving from the RAM and one in the read pipeline.
  localparam int BUF_DEPTH = 3;

  // Cycles from fifo_rden to valid fifo_rddata in the async_fifo RAM.
  localparam int RD_LATENCY = 1;

  // Buffer pointers and occupancy (0..3) both fit in two bits.
  typedef logic [1:0] ptr_t;

  // Advance a buffer pointer, wrapping 2 -> 0.
  function automatic ptr_t ptr_inc3(input ptr_t p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus the outgoing valid/ready stream of fifo_rd_stream.
// master = the stream reader (drives rden and the stream); slave = FIFO/consumer side.
interface fifo_rd_stream_if #(
  parameter int WIDTH = 64
) ();
  import fifo_pkg::*;

  // async_fifo read port
  logic             fifo_empty;
  logic             fifo_rden;
  logic [WIDTH-1:0] fifo_rddata;

  // outgoing packet stream
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (
    input  fifo_empty,
    output fifo_rden,
    input  fifo_rddata,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_last
  );

  modport slave (
    output fifo_empty,
    input  fifo_rden,
    output fifo_rddata,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_last
  );

endinterface

// File: rtl/stream_buf3.sv
// Three-entry circular register buffer with push/pop and occupancy.
// valid and data are driven purely from registers, so downstream sees no
// combinational path back through this block.
module stream_buf3
  import fifo_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             rdclk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output ptr_t             occ,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  ptr_t             head;
  ptr_t             tail;

  // Entry storage: cleared on reset so the stream data reads zero, written at tail on push.
  always_ff @(posedge rdclk) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[tail] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves occ unchanged.
  always_ff @(posedge rdclk) begin
    if (!rst_n) begin
      head <= 2'd0;
      tail <= 2'd0;
      occ  <= 2'd0;
    end else begin
      if (push) begin
        tail <= ptr_inc3(tail);
      end
      if (pop) begin
        head <= ptr_inc3(head);
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign valid = (occ != 2'd0);
  assign data  = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of async_fifo: issues credit-limited reads, absorbs the
// one-cycle RAM latency in a 3-entry buffer and emits a framed valid/ready
// stream with m_last every PKT_LEN beats and a completed-packet counter.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int PKT_LEN = 256,
  parameter int CNT_W   = 16
) (
  input  logic             rdclk,
  input  logic             rst_n,
  fifo_rd_stream_if.master bus,
  output logic [CNT_W-1:0] pkt_count
);

  localparam int                IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  logic             rden_p0;
  logic             vld_p1;
  ptr_t             occ;
  logic             buf_valid;
  logic [WIDTH-1:0] buf_data;
  logic             beat_hs;
  logic             last_beat;
  logic [IDX_W-1:0] beat_idx;

  // ---- stage p0: read issue ----
  // Credit check counts words already buffered plus the one possibly in the
  // RAM pipeline, so every returning word always has a free slot. m_ready is
  // deliberately not part of this term.
  assign rden_p0 = rst_n && !bus.fifo_empty &&
                   (({1'b0, occ} + {2'b00, vld_p1}) < 3'(BUF_DEPTH));
  assign bus.fifo_rden = rden_p0;

  // ---- stage p1: RAM output valid one cycle after rden ----
  // Tracks the read in flight; rddata is only consumed when this is set.
  always_ff @(posedge rdclk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rden_p0;
    end
  end

  // ---- stage p2: registered output buffer ----
  stream_buf3 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .rdclk     (rdclk),
    .rst_n     (rst_n),
    .push      (vld_p1),
    .push_data (bus.fifo_rddata),
    .pop       (beat_hs),
    .occ       (occ),
    .valid     (buf_valid),
    .data      (buf_data)
  );

  assign beat_hs   = buf_valid && bus.m_ready;
  assign last_beat = (beat_idx == LAST_IDX);

  assign bus.m_valid = buf_valid;
  assign bus.m_data  = buf_data;
  assign bus.m_last  = buf_valid && last_beat;

  // Packet framing: beat index advances per accepted beat and the packet
  // counter bumps when the final beat of a packet is accepted. Bubbles from an
  // empty FIFO leave both untouched.
  always_ff @(posedge rdclk) begin
    if (!rst_n) begin
      beat_idx  <= '0;
      pkt_count <= '0;
    end else if (beat_hs) begin
      if (last_beat) begin
        beat_idx  <= '0;
        pkt_count <= pkt_count + CNT_W'(1);
      end else begin
        beat_idx <= beat_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream with a behavioural async_fifo read-port model.
module tb_fifo_rd_stream;

  localparam int WIDTH = 64;
  localparam int PKT   = 4;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic             rdclk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] pkt_count;

  fifo_rd_stream_if #(.WIDTH(WIDTH)) bus ();

  fifo_rd_stream #(
    .WIDTH   (WIDTH),
    .PKT_LEN (PKT),
    .CNT_W   (CNT_W)
  ) dut (
    .rdclk     (rdclk),
    .rst_n     (rst_n),
    .bus       (bus),
    .pkt_count (pkt_count)
  );

  always #5 rdclk = ~rdclk;

  // FIFO model: word array with read/write indices, one-cycle read latency,
  // garbage on rddata when not reading, flush on request.
  logic [WIDTH-1:0] fmem [1024];
  int               wr_i = 0;
  int               rd_i = 0;
  logic             fifo_flush = 1'b0;
  logic [WIDTH-1:0] rddata_r = '0;

  assign bus.fifo_empty  = (wr_i == rd_i);
  assign bus.fifo_rddata = rddata_r;

  always @(posedge rdclk) begin
    if (fifo_flush) begin
      rd_i <= wr_i;
    end else if (bus.fifo_rden) begin
      rddata_r <= fmem[rd_i];
      rd_i     <= rd_i + 1;
    end else begin
      rddata_r <= {$urandom, $urandom};
    end
  end

  // Reference state
  logic [WIDTH-1:0] exp_q [$];
  beat_t            obs_q [$];
  int               mdl_n;
  int               rd_cnt;
  int               hs_cnt;
  int               checks = 0;
  int               errors = 0;

  // Per-cycle samples
  logic             s_valid, s_last, s_rden, s_empty;
  logic [WIDTH-1:0] s_data;
  logic [CNT_W-1:0] s_cnt;
  int               s_out;

  task automatic fpush(input logic [WIDTH-1:0] v);
    fmem[wr_i] = v;
    wr_i = wr_i + 1;
    exp_q.push_back(v);
  endtask

  // Sample at the falling edge, record handshakes/reads due at the next rising
  // edge, then return just after that rising edge ready for new stimulus.
  task automatic cycle();
    beat_t b;
    @(negedge rdclk);
    s_valid = bus.m_valid;
    s_last  = bus.m_last;
    s_data  = bus.m_data;
    s_rden  = bus.fifo_rden;
    s_empty = bus.fifo_empty;
    s_cnt   = pkt_count;
    s_out   = rd_cnt - hs_cnt;
    if (!rst_n) begin
      rd_cnt = 0;
      hs_cnt = 0;
    end else begin
      if (s_rden) rd_cnt++;
      if (s_valid && bus.m_ready) begin
        hs_cnt++;
        b.last = s_last;
        b.data = s_data;
        obs_q.push_back(b);
      end
    end
    @(posedge rdclk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_flush = 1'b1;
    cycle();
    rst_n = 1'b1;
    fifo_flush = 1'b0;
    exp_q.delete();
    obs_q.delete();
    mdl_n = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) fpush({$urandom, $urandom});
    for (int c = 0; c < 5; c++) begin
      fifo_flush = (c == 4);
      cycle();
      checks++;
      if ({s_rden, s_valid, s_last} !== 3'b000 || s_cnt !== '0 || s_data !== '0) begin
        errors++;
        $display("FAIL reset_c%0d got rden=%b valid=%b last=%b cnt=%0d data=%0h want all zero",
                 c, s_rden, s_valid, s_last, s_cnt, s_data);
      end
    end
    rst_n = 1'b1;
    fifo_flush = 1'b0;
    exp_q.delete();
    obs_q.delete();
    mdl_n = 0;
    cycle();
    checks++;
    if (s_valid !== 1'b0 || s_rden !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got valid=%b rden=%b want 0 0", s_valid, s_rden);
    end
  endtask

  task automatic test_streaming();
    beat_t b;
    logic [WIDTH-1:0] ew;
    logic el;
    int nvalid = 0;
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 12; i++) fpush(WIDTH'(i));
    for (int c = 0; c < 16; c++) begin
      cycle();
      if (c == 0) begin
        checks++;
        if (s_rden !== 1'b1 || s_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_c0 got rden=%b valid=%b want 1 0", s_rden, s_valid);
        end
      end
      if (c == 1) begin
        checks++;
        if (s_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_c1 got valid=%b want 0", s_valid);
        end
      end
      if (c >= 2 && c <= 13 && s_valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 12) begin
      errors++;
      $display("FAIL stream_consecutive got %0d valid cycles want 12", nvalid);
    end
    while (obs_q.size() > 0) begin
      b = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra got %0h want no beat", b.data);
      end else begin
        ew = exp_q.pop_front();
        el = (mdl_n % PKT) == PKT - 1;
        if (b.data !== ew || b.last !== el) begin
          errors++;
          $display("FAIL stream_beat%0d got data=%0h last=%b want data=%0h last=%b",
                   mdl_n, b.data, b.last, ew, el);
        end
      end
      mdl_n++;
    end
    checks++;
    if (exp_q.size() != 0 || s_cnt !== 2'd3) begin
      errors++;
      $display("FAIL stream_end got missing=%0d cnt=%0d want 0 3", exp_q.size(), s_cnt);
    end
  endtask

  task automatic test_backpressure();
    beat_t b;
    logic [WIDTH-1:0] ew, hd;
    logic el, hv, hl;
    hv = 1'b0; hd = '0; hl = 1'b0;
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 20; i++) fpush({$urandom, $urandom});
    for (int c = 0; c < 40; c++) begin
      if (c == 5)  bus.m_ready = 1'b0;
      if (c == 15) bus.m_ready = 1'b1;
      cycle();
      checks++;
      if (s_out > 3 || s_rden !== (!s_empty && s_out < 3)) begin
        errors++;
        $display("FAIL bp_credit_c%0d got rden=%b outstanding=%0d want rden=%b",
                 c, s_rden, s_out, (!s_empty && s_out < 3));
      end
      if (c >= 5 && c < 15) begin
        if (hv) begin
          checks++;
          if (s_valid !== 1'b1 || s_data !== hd || s_last !== hl) begin
            errors++;
            $display("FAIL bp_hold_c%0d got valid=%b data=%0h last=%b want 1 %0h %b",
                     c, s_valid, s_data, s_last, hd, hl);
          end
        end
        hv = s_valid; hd = s_data; hl = s_last;
      end
      if (c == 14) begin
        checks++;
        if (s_out != 3 || s_rden !== 1'b0) begin
          errors++;
          $display("FAIL bp_full got outstanding=%0d rden=%b want 3 0", s_out, s_rden);
        end
      end
    end
    while (obs_q.size() > 0) begin
      b = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bp_extra got %0h want no beat", b.data);
      end else begin
        ew = exp_q.pop_front();
        el = (mdl_n % PKT) == PKT - 1;
        if (b.data !== ew || b.last !== el) begin
          errors++;
          $display("FAIL bp_beat%0d got data=%0h last=%b want data=%0h last=%b",
                   mdl_n, b.data, b.last, ew, el);
        end
      end
      mdl_n++;
    end
    checks++;
    if (exp_q.size() != 0 || s_cnt !== CNT_W'((mdl_n / PKT) % 4)) begin
      errors++;
      $display("FAIL bp_end got missing=%0d cnt=%0d want 0 %0d", exp_q.size(), s_cnt, (mdl_n / PKT) % 4);
    end
  endtask

  task automatic test_empty_mid_packet();
    beat_t b;
    logic [WIDTH-1:0] ew;
    logic el;
    do_reset();
    bus.m_ready = 1'b1;
    fpush({$urandom, $urandom});
    fpush({$urandom, $urandom});
    for (int c = 0; c < 10; c++) cycle();
    checks++;
    if (s_valid !== 1'b0 || hs_cnt != 2 || s_cnt !== '0) begin
      errors++;
      $display("FAIL empty_bubble got valid=%b beats=%0d cnt=%0d want 0 2 0", s_valid, hs_cnt, s_cnt);
    end
    fpush({$urandom, $urandom});
    fpush({$urandom, $urandom});
    for (int c = 0; c < 8; c++) cycle();
    while (obs_q.size() > 0) begin
      b = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL empty_extra got %0h want no beat", b.data);
      end else begin
        ew = exp_q.pop_front();
        el = (mdl_n % PKT) == PKT - 1;
        if (b.data !== ew || b.last !== el) begin
          errors++;
          $display("FAIL empty_beat%0d got data=%0h last=%b want data=%0h last=%b",
                   mdl_n, b.data, b.last, ew, el);
        end
      end
      mdl_n++;
    end
    checks++;
    if (mdl_n != 4 || s_cnt !== 2'd1) begin
      errors++;
      $display("FAIL empty_end got beats=%0d cnt=%0d want 4 1", mdl_n, s_cnt);
    end
  endtask

  task automatic test_reset_mid_packet();
    beat_t b;
    logic [WIDTH-1:0] ew;
    logic el;
    int n = 0;
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 6; i++) fpush({$urandom, $urandom});
    while (hs_cnt < 2 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL rstmid_timeout got %0d beats want 2", hs_cnt);
    end
    rst_n = 1'b0;
    fifo_flush = 1'b1;
    cycle();
    checks++;
    if (s_rden !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_rden got %b want 0", s_rden);
    end
    rst_n = 1'b1;
    fifo_flush = 1'b0;
    exp_q.delete();
    obs_q.delete();
    mdl_n = 0;
    cycle();
    checks++;
    if (s_valid !== 1'b0 || s_cnt !== '0) begin
      errors++;
      $display("FAIL rstmid_after got valid=%b cnt=%0d want 0 0", s_valid, s_cnt);
    end
    for (int i = 0; i < 4; i++) fpush({$urandom, $urandom});
    for (int c = 0; c < 8; c++) cycle();
    while (obs_q.size() > 0) begin
      b = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rstmid_extra got %0h want no beat", b.data);
      end else begin
        ew = exp_q.pop_front();
        el = (mdl_n % PKT) == PKT - 1;
        if (b.data !== ew || b.last !== el) begin
          errors++;
          $display("FAIL rstmid_beat%0d got data=%0h last=%b want data=%0h last=%b",
                   mdl_n, b.data, b.last, ew, el);
        end
      end
      mdl_n++;
    end
    checks++;
    if (mdl_n != 4 || s_cnt !== 2'd1) begin
      errors++;
      $display("FAIL rstmid_end got beats=%0d cnt=%0d want 4 1", mdl_n, s_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    beat_t b;
    logic [WIDTH-1:0] ew;
    logic el;
    logic [CNT_W-1:0] prev;
    int seq [$];
    int n = 0;
    prev = '0;
    do_reset();
    for (int i = 0; i < 40; i++) fpush({$urandom, $urandom});
    while (hs_cnt < 40 && n < 400) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      cycle();
      checks++;
      if (s_out > 3 || s_rden !== (!s_empty && s_out < 3)) begin
        errors++;
        $display("FAIL wrap_credit_c%0d got rden=%b outstanding=%0d", n, s_rden, s_out);
      end
      if (s_cnt !== prev) begin
        seq.push_back(int'(s_cnt));
        prev = s_cnt;
      end
      n++;
    end
    bus.m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (s_cnt !== prev) begin
        seq.push_back(int'(s_cnt));
        prev = s_cnt;
      end
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL wrap_timeout got %0d beats want 40", hs_cnt);
    end
    while (obs_q.size() > 0) begin
      b = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wrap_extra got %0h want no beat", b.data);
      end else begin
        ew = exp_q.pop_front();
        el = (mdl_n % PKT) == PKT - 1;
        if (b.data !== ew || b.last !== el) begin
          errors++;
          $display("FAIL wrap_beat%0d got data=%0h last=%b want data=%0h last=%b",
                   mdl_n, b.data, b.last, ew, el);
        end
      end
      mdl_n++;
    end
    checks++;
    if (seq.size() != 10) begin
      errors++;
      $display("FAIL wrap_len got %0d count changes want 10", seq.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (seq[k] != (k + 1) % 4) begin
          errors++;
          $display("FAIL wrap_seq%0d got %0d want %0d", k, seq[k], (k + 1) % 4);
        end
      end
    end
  endtask

  initial begin
    bus.m_ready = 1'b0;
    mdl_n  = 0;
    rd_cnt = 0;
    hs_cnt = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_mid_packet();
    test_reset_mid_packet();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
